// File: rtl/mux_pkg.sv
// mux_pkg: shared sizing helper, lane-index type and out-of-range output value for the lane multiplexer
package mux_pkg;

   typedef int unsigned lane_idx_t;

   localparam bit MUX_OOR_VALUE = '0;

   function automatic int sel_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mux_sel_comb.sv
// mux_sel_comb: combinational lane selector with select range check
module mux_sel_comb
   import mux_pkg::*;
#(
   parameter int WIDTH  = 1,
   parameter int NUM_IN = 2,
   parameter int SEL_W  = sel_w(NUM_IN)
) (
   input  logic [NUM_IN*WIDTH-1:0] in,
   input  logic [SEL_W-1:0]        s,
   output logic [WIDTH-1:0]        lane,
   output logic                    oor
);

   // Pick the addressed lane; an unmatched select leaves the out-of-range value
   always_comb begin
      lane = {WIDTH{MUX_OOR_VALUE}};
      oor  = {1'b0, s} >= (SEL_W+1)'(NUM_IN);
      for (lane_idx_t i = 0; i < NUM_IN; i++)
         if (s == SEL_W'(i)) lane = in[i*WIDTH +: WIDTH];
   end

endmodule

// File: rtl/mux_2to1.sv
// mux_2to1: registered N:1 lane multiplexer; MUX_SEL_ERR_EN adds a registered out-of-range select flag
module mux_2to1
   import mux_pkg::*;
#(
   parameter int WIDTH  = 1,
   parameter int NUM_IN = 2,
   parameter int SEL_W  = sel_w(NUM_IN)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_IN*WIDTH-1:0] in,
   input  logic [SEL_W-1:0]        s,
   output logic [WIDTH-1:0]        op
`ifdef MUX_SEL_ERR_EN
   ,
   output logic                    sel_err
`endif
);

   logic [WIDTH-1:0] lane;

`ifdef MUX_SEL_ERR_EN
   logic oor;

   mux_sel_comb #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) u_sel (
      .in(in), .s(s), .lane(lane), .oor(oor)
   );

   // Flag out-of-range selects in step with the data register
   always_ff @(posedge clk or posedge rst)
      if (rst) sel_err <= 1'b0;
      else sel_err <= oor;
`else
   logic oor_unused;

   mux_sel_comb #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) u_sel (
      .in(in), .s(s), .lane(lane), .oor(oor_unused)
   );
`endif

   // Sample the selected lane every edge; reset clears it immediately
   always_ff @(posedge clk or posedge rst)
      if (rst) op <= '0;
      else op <= lane;

endmodule

// File: tb/tb_mux_2to1.sv
// tb_mux_2to1: directed checks of default, 3-lane and 8-bit/4-lane registered multiplexers
module tb_mux_2to1;

   logic clk = 1'b0;
   logic rst;
   logic [1:0]  in0;
   logic [0:0]  s0;
   logic [0:0]  op0;
   logic [11:0] in1;
   logic [1:0]  s1;
   logic [3:0]  op1;
   logic [31:0] in2;
   logic [1:0]  s2;
   logic [7:0]  op2;
`ifdef MUX_SEL_ERR_EN
   logic err0, err1, err2;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mux_2to1 u0 (
      .clk(clk), .rst(rst), .in(in0), .s(s0), .op(op0)
`ifdef MUX_SEL_ERR_EN
      , .sel_err(err0)
`endif
   );

   mux_2to1 #(.WIDTH(4), .NUM_IN(3)) u1 (
      .clk(clk), .rst(rst), .in(in1), .s(s1), .op(op1)
`ifdef MUX_SEL_ERR_EN
      , .sel_err(err1)
`endif
   );

   mux_2to1 #(.WIDTH(8), .NUM_IN(4)) u2 (
      .clk(clk), .rst(rst), .in(in2), .s(s2), .op(op2)
`ifdef MUX_SEL_ERR_EN
      , .sel_err(err2)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   logic [1:0] sel_tab [4] = '{2'd3, 2'd2, 2'd0, 2'd1};
   logic [3:0] exp_tab [4] = '{4'h0, 4'hC, 4'hA, 4'hB};
   logic       err_tab [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

   initial begin
      rst = 1'b1;
      in0 = 2'b01;
      s0  = 1'b0;
      in1 = {4'hC, 4'hB, 4'hA};
      s1  = 2'd0;
      in2 = 32'h44332211;
      s2  = 2'd3;
      #2;
      chk("rst_async_op0", op0, 0);
      chk("rst_async_op1", op1, 0);
      chk("rst_async_op2", op2, 0);
`ifdef MUX_SEL_ERR_EN
      chk("rst_async_err1", err1, 0);
`endif
      tick;
      chk("rst_hold_op0", op0, 0);
      rst = 1'b0;
      tick;
      chk("release_op0", op0, 1);
      chk("release_op2", op2, 8'h44);
      s0 = 1'b1;
      #2;
      chk("pre_edge_hold", op0, 1);
      tick;
      chk("sel1_op0", op0, 0);
      in0 = 2'b10;
      tick;
      chk("follow_hi", op0, 1);
      in0 = 2'b00;
      tick;
      chk("follow_lo", op0, 0);
      in0 = 2'b10;
      tick;
      chk("pre_rst", op0, 1);
      #3;
      rst = 1'b1;
      #1;
      chk("mid_rst_op0", op0, 0);
      chk("mid_rst_op2", op2, 0);
      tick;
      chk("rst_hold2", op0, 0);
      rst = 1'b0;
      tick;
      chk("resume", op0, 1);
      s0  = 1'b0;
      in0 = 2'b01;
      tick;
      chk("sel0_op0", op0, 1);
      for (int i = 0; i < 4; i++) begin
         s1 = sel_tab[i];
         tick;
         chk("lane3_op", op1, exp_tab[i]);
`ifdef MUX_SEL_ERR_EN
         chk("lane3_err", err1, err_tab[i]);
`endif
      end
      for (int i = 0; i < 4; i++) begin
         s2 = 2'(i);
         tick;
         chk("wide_op", op2, 32'((i + 1) * 8'h11));
`ifdef MUX_SEL_ERR_EN
         chk("wide_err", err2, 0);
`endif
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
